// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM states, forwarding encodings and widths for the pipeline controller
package pipe_ctrl_pkg;
  localparam int REG_AW_DEF = 5;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_LU = 2'd1, ST_BUSY = 2'd2, ST_FLUSH = 2'd3} ctrl_state_t;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/pipe_ctrl_fwd.sv
// pipe_ctrl_fwd: combinational EX operand forwarding select, MEM result preferred over WB
module pipe_ctrl_fwd
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              regwrite_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              regwrite_wb,
  output logic [1:0]        fwd
);
  assign fwd = (regwrite_mem && rd_mem != '0 && rd_mem == rs) ? FWD_MEM :
               (regwrite_wb && rd_wb != '0 && rd_wb == rs)    ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: hazard/stall/flush control, forwarding selects, state FSM and perf counters
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              use_rs1_id,
  input  logic              use_rs2_id,
  input  logic [REG_AW-1:0] rs1_ex,
  input  logic [REG_AW-1:0] rs2_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              regwrite_ex,
  input  logic              regwrite_mem,
  input  logic              regwrite_wb,
  input  logic              memread_ex,
  input  logic              branch_taken_mem,
  input  logic              ex_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              ex_kill,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic              pipeline_stall,
  output logic [1:0]        ctrl_state,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  function automatic logic id_reads(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] r1,
                                    input logic u1, input logic [REG_AW-1:0] r2, input logic u2);
    return rd != '0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
  endfunction
  ctrl_state_t state_q, state_d;
  logic        load_use, raw, hz;
  logic [1:0]  fwd_a, fwd_b;
  assign load_use = memread_ex && id_reads(rd_ex, rs1_id, use_rs1_id, rs2_id, use_rs2_id);
  // Without forwarding, any in-flight producer in EX or MEM must drain before ID may read
  assign raw = (FWD_EN == 0) &&
               ((regwrite_ex && id_reads(rd_ex, rs1_id, use_rs1_id, rs2_id, use_rs2_id)) ||
                (regwrite_mem && id_reads(rd_mem, rs1_id, use_rs1_id, rs2_id, use_rs2_id)));
  assign hz = load_use || raw;
  pipe_ctrl_fwd #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(rs1_ex), .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
    .rd_wb(rd_wb), .regwrite_wb(regwrite_wb), .fwd(fwd_a)
  );
  pipe_ctrl_fwd #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(rs2_ex), .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
    .rd_wb(rd_wb), .regwrite_wb(regwrite_wb), .fwd(fwd_b)
  );
  always_ff @(posedge clk)
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  always_comb begin
    state_d = branch_taken_mem ? ST_FLUSH : ex_busy ? ST_BUSY : hz ? ST_LU : ST_RUN;
  end
  always_comb begin
    pc_write       = !reset && (branch_taken_mem || !(ex_busy || hz));
    if_id_write    = pc_write;
    id_ex_bubble   = !reset && !branch_taken_mem && !ex_busy && hz;
    if_id_flush    = reset || branch_taken_mem;
    id_ex_flush    = reset || branch_taken_mem;
    ex_mem_flush   = reset || branch_taken_mem || ex_busy;
    ex_kill        = reset || (branch_taken_mem && ex_busy);
    pipeline_stall = !reset && !branch_taken_mem && (ex_busy || hz);
    forwardA       = (reset || FWD_EN == 0) ? FWD_RF : fwd_a;
    forwardB       = (reset || FWD_EN == 0) ? FWD_RF : fwd_b;
  end
  assign ctrl_state = state_q;
  always_ff @(posedge clk)
    if (reset) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cyc_cnt   <= cyc_cnt + 1'b1;
      stall_cnt <= stall_cnt + CNT_W'(pipeline_stall && stall_cnt != CNT_MAX);
      flush_cnt <= flush_cnt + CNT_W'(branch_taken_mem && flush_cnt != CNT_MAX);
    end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: table-driven combinational checks plus directed multi-cycle sequences
module tb_pipe_ctrl_unit;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic use_rs1_id, use_rs2_id, regwrite_ex, regwrite_mem, regwrite_wb;
  logic memread_ex, branch_taken_mem, ex_busy;
  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, ex_kill, pipeline_stall;
  logic [1:0] forwardA, forwardB, ctrl_state;
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
  logic n_pc_write, n_if_id_write, n_id_ex_bubble, n_if_id_flush, n_id_ex_flush, n_ex_mem_flush, n_ex_kill, n_stall;
  logic [1:0] n_fa, n_fb, n_state;
  logic [3:0] n_cyc, n_stall_cnt, n_flush_cnt;
  logic [11:0] obs, n_obs;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb), .regwrite_ex(regwrite_ex),
    .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb), .memread_ex(memread_ex),
    .branch_taken_mem(branch_taken_mem), .ex_busy(ex_busy), .pc_write(pc_write),
    .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .ex_kill(ex_kill),
    .forwardA(forwardA), .forwardB(forwardB), .pipeline_stall(pipeline_stall),
    .ctrl_state(ctrl_state), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl_unit #(.FWD_EN(0), .CNT_W(4)) dut_nf (
    .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb), .regwrite_ex(regwrite_ex),
    .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb), .memread_ex(memread_ex),
    .branch_taken_mem(branch_taken_mem), .ex_busy(ex_busy), .pc_write(n_pc_write),
    .if_id_write(n_if_id_write), .id_ex_bubble(n_id_ex_bubble), .if_id_flush(n_if_id_flush),
    .id_ex_flush(n_id_ex_flush), .ex_mem_flush(n_ex_mem_flush), .ex_kill(n_ex_kill),
    .forwardA(n_fa), .forwardB(n_fb), .pipeline_stall(n_stall),
    .ctrl_state(n_state), .cyc_cnt(n_cyc), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  assign obs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush,
                ex_kill, pipeline_stall, forwardA, forwardB};
  assign n_obs = {n_pc_write, n_if_id_write, n_id_ex_bubble, n_if_id_flush, n_id_ex_flush,
                  n_ex_mem_flush, n_ex_kill, n_stall, n_fa, n_fb};

  // Expected output packing: {pc_write, if_id_write, bubble, if_id_f, id_ex_f, ex_mem_f, kill, stall, fwdA, fwdB}
  localparam logic [11:0] O_IDLE  = 12'b110000000000;
  localparam logic [11:0] O_STALL = 12'b001000010000;
  localparam logic [11:0] O_BUSY  = 12'b000001010000;
  localparam logic [11:0] O_BR    = 12'b110111000000;
  localparam logic [11:0] O_BRK   = 12'b110111100000;
  localparam logic [11:0] O_RST   = 12'b000111100000;

  typedef struct {
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic u1, u2, rw_ex, rw_mem, rw_wb, mr, br, busy;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[16];

  function automatic vec_t mk(input logic [4:0] r1i, r2i, r1e, r2e, rde, rdm, rdw,
                              input logic u1, u2, rwe, rwm, rww, mr, br, busy,
                              input logic [11:0] exp);
    vec_t v;
    v.rs1_id = r1i; v.rs2_id = r2i; v.rs1_ex = r1e; v.rs2_ex = r2e;
    v.rd_ex = rde; v.rd_mem = rdm; v.rd_wb = rdw;
    v.u1 = u1; v.u2 = u2; v.rw_ex = rwe; v.rw_mem = rwm; v.rw_wb = rww;
    v.mr = mr; v.br = br; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rs1_id = v.rs1_id; rs2_id = v.rs2_id; rs1_ex = v.rs1_ex; rs2_ex = v.rs2_ex;
    rd_ex = v.rd_ex; rd_mem = v.rd_mem; rd_wb = v.rd_wb;
    use_rs1_id = v.u1; use_rs2_id = v.u2; regwrite_ex = v.rw_ex;
    regwrite_mem = v.rw_mem; regwrite_wb = v.rw_wb; memread_ex = v.mr;
    branch_taken_mem = v.br; ex_busy = v.busy;
  endtask

  task automatic clear();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //                r1i r2i r1e r2e rde rdm rdw u1 u2 rwe rwm rww mr br busy exp
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
    vecs[1]  = mk(5, 0, 0, 0, 5, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, O_STALL);
    vecs[2]  = mk(5, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, O_IDLE);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, O_IDLE);
    vecs[4]  = mk(1, 9, 0, 0, 9, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, O_STALL);
    vecs[5]  = mk(0, 0, 7, 7, 0, 7, 7, 0, 0, 0, 1, 1, 0, 0, 0, 12'b110000001010);
    vecs[6]  = mk(0, 0, 7, 7, 0, 0, 7, 0, 0, 0, 1, 1, 0, 0, 0, 12'b110000000101);
    vecs[7]  = mk(0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, O_IDLE);
    vecs[8]  = mk(0, 0, 7, 3, 0, 7, 3, 0, 0, 0, 1, 1, 0, 0, 0, 12'b110000001001);
    vecs[9]  = mk(0, 0, 7, 0, 0, 7, 7, 0, 0, 0, 0, 1, 0, 0, 0, 12'b110000000100);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_BUSY);
    vecs[11] = mk(5, 0, 0, 0, 5, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, O_BUSY);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BR);
    vecs[13] = mk(5, 0, 0, 0, 5, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, O_BRK);
    vecs[14] = mk(0, 3, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, O_IDLE);
    vecs[15] = mk(0, 0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 1, 0, 12'b110111001000);
    clear();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      #1 chk($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
      @(posedge clk);
      #1;
    end
    // reset outputs override hazards, busy, branch and forwarding matches
    apply(vecs[13]);
    rs1_ex = 7; rd_mem = 7; regwrite_mem = 1'b1;
    reset = 1'b1;
    #1 chk("reset_outs", 32'(obs), 32'(O_RST));
    chk("reset_outs_nf", 32'(n_obs), 32'(O_RST));
    @(posedge clk);
    #1 chk("reset_state", 32'(ctrl_state), 0);
    chk("reset_cyc", cyc_cnt, 0);
    // load-use: lw x5 in EX, ID reads x5
    clear();
    reset = 1'b0;
    rd_ex = 5; memread_ex = 1'b1; regwrite_ex = 1'b1; rs1_id = 5; use_rs1_id = 1'b1;
    #1 chk("lu_pc_write", 32'(pc_write), 0);
    chk("lu_bubble", 32'(id_ex_bubble), 1);
    @(posedge clk);
    #1 chk("lu_state", 32'(ctrl_state), 1);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_cyc", cyc_cnt, 1);
    clear();
    #1 chk("lu_release_pc", 32'(pc_write), 1);
    @(posedge clk);
    #1 chk("lu_back_run", 32'(ctrl_state), 0);
    chk("lu_stall_hold", stall_cnt, 1);
    // four busy cycles with a taken branch in the second
    for (int c = 1; c <= 4; c++) begin
      ex_busy = 1'b1;
      branch_taken_mem = (c == 2);
      #1 chk($sformatf("busy_c%0d", c), 32'(obs), 32'((c == 2) ? O_BRK : O_BUSY));
      @(posedge clk);
      #1 chk($sformatf("busy_state_c%0d", c), 32'(ctrl_state), (c == 2) ? 3 : 2);
    end
    chk("busy_stall_cnt", stall_cnt, 4);
    chk("busy_flush_cnt", flush_cnt, 1);
    chk("busy_cyc", cyc_cnt, 6);
    // reset while in ST_BUSY
    branch_taken_mem = 1'b0;
    reset = 1'b1;
    #1 chk("midbusy_reset_outs", 32'(obs), 32'(O_RST));
    @(posedge clk);
    #1 chk("midbusy_state", 32'(ctrl_state), 0);
    chk("midbusy_stall_cnt", stall_cnt, 0);
    chk("midbusy_flush_cnt", flush_cnt, 0);
    chk("midbusy_cyc", cyc_cnt, 0);
    chk("midbusy_nf_state", 32'(n_state), 0);
    // no-forwarding: add x3 in EX, ID reads x3 via rs2
    clear();
    reset = 1'b0;
    rd_ex = 3; regwrite_ex = 1'b1; rs2_id = 3; use_rs2_id = 1'b1; rs1_ex = 3; rs2_ex = 3;
    #1 chk("nf_ex_pc", 32'(n_pc_write), 0);
    chk("nf_ex_bubble", 32'(n_id_ex_bubble), 1);
    chk("nf_ex_fwd_pc", 32'(pc_write), 1);
    @(posedge clk);
    #1 chk("nf_ex_state", 32'(n_state), 1);
    rd_ex = 0; regwrite_ex = 1'b0; rd_mem = 3; regwrite_mem = 1'b1;
    #1 chk("nf_mem_pc", 32'(n_pc_write), 0);
    chk("nf_mem_fa", 32'(n_fa), 0);
    chk("nf_mem_fwd_fa", 32'(forwardA), 2);
    @(posedge clk);
    #1 chk("nf_mem_state", 32'(n_state), 1);
    rd_mem = 0; regwrite_mem = 1'b0; rd_wb = 3; regwrite_wb = 1'b1;
    #1 chk("nf_wb_pc", 32'(n_pc_write), 1);
    chk("nf_wb_stall", 32'(n_stall), 0);
    chk("nf_wb_fb", 32'(n_fb), 0);
    chk("nf_wb_fwd_fb", 32'(forwardB), 1);
    @(posedge clk);
    #1 chk("nf_wb_state", 32'(n_state), 0);
    chk("nf_stall_cnt", 32'(n_stall_cnt), 2);
    // counter saturation and wrap on the 4-bit instance
    clear();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    ex_busy = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("sat_stall_cnt", 32'(n_stall_cnt), 15);
    chk("wrap_cyc", 32'(n_cyc), 4);
    chk("wide_stall_cnt", stall_cnt, 20);
    ex_busy = 1'b0;
    branch_taken_mem = 1'b1;
    repeat (17) @(posedge clk);
    #1 chk("sat_flush_cnt", 32'(n_flush_cnt), 15);
    chk("wide_flush_cnt", flush_cnt, 17);
    chk("sat_stall_hold", 32'(n_stall_cnt), 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
